// File: rtl/sc_stream_counter.sv
// sc_stream_counter: counts ones over a 2^DATAWD qualified-bit window after skipping SKIP leading bits
module sc_stream_counter #(
  parameter int DATAWD = 8,
  parameter int SKIP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_bit,
  input  logic              in_en,
  output logic [DATAWD:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_RUN, S_HOLD} state_t;
  localparam logic [7:0] SKIP_LAST = 8'(SKIP - 1);
  localparam logic [DATAWD-1:0] WIN_LAST = '1;
  state_t state_q, state_d;
  logic [7:0] skip_cnt_q, skip_cnt_d;
  logic [DATAWD-1:0] win_cnt_q, win_cnt_d;
  logic [DATAWD:0] ones_q, ones_d, out_data_q, out_data_d;
  logic last_bit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (SKIP == 0) ? S_RUN : S_SKIP;
      S_SKIP: if (in_en && skip_cnt_q == SKIP_LAST) state_d = S_RUN;
      S_RUN:  if (last_bit) state_d = S_HOLD;
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end
  // counters only live inside their own state, so leaving it (or abort) clears them
  always_comb begin
    last_bit   = state_q == S_RUN && in_en && win_cnt_q == WIN_LAST;
    skip_cnt_d = (abort || state_q != S_SKIP) ? '0 : skip_cnt_q + 8'(in_en);
    win_cnt_d  = (abort || state_q != S_RUN) ? '0 : win_cnt_q + DATAWD'(in_en);
    ones_d     = (abort || state_q != S_RUN) ? '0 : ones_q + (DATAWD+1)'(in_en & in_bit);
    out_data_d = (!abort && last_bit) ? ones_q + (DATAWD+1)'(in_bit) : out_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_cnt_q <= '0;
      win_cnt_q  <= '0;
      ones_q     <= '0;
      out_data_q <= '0;
    end else begin
      skip_cnt_q <= skip_cnt_d;
      win_cnt_q  <= win_cnt_d;
      ones_q     <= ones_d;
      out_data_q <= out_data_d;
    end
  end
  always_comb begin
    out_valid = state_q == S_HOLD;
    busy      = state_q != S_IDLE;
    out_data  = out_data_q;
  end
endmodule

// File: tb/tb_sc_stream_counter.sv
// tb_sc_stream_counter: checks two DUTs (SKIP=1, SKIP=0) against a window-level reference model
module tb_sc_stream_counter;
  logic clk = 0, rst = 0, start = 0, abort = 0, in_bit = 0, in_en = 0, out_ready = 0;
  logic [3:0] d0, d1;
  logic v0, v1, b0, b1;
  int total = 0, bad = 0;
  bit act[2], hold[2];
  int nq[2], sum[2], ed[2];
  int skp[2] = '{1, 0};
  always #5 clk = ~clk;
  sc_stream_counter #(.DATAWD(3), .SKIP(1)) u0 (.clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_bit(in_bit), .in_en(in_en), .out_data(d0), .out_valid(v0), .out_ready(out_ready), .busy(b0));
  sc_stream_counter #(.DATAWD(3), .SKIP(0)) u1 (.clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_bit(in_bit), .in_en(in_en), .out_data(d1), .out_valid(v1), .out_ready(out_ready), .busy(b1));
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; hold[k] = 0; nq[k] = 0; sum[k] = 0; ed[k] = 0;
    end
  endtask
  // window-level view: the result is the sum of qualified bits at positions SKIP .. SKIP+7 after start
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (abort) begin
        act[k] = 0; hold[k] = 0;
      end else if (hold[k]) begin
        if (out_ready) hold[k] = 0;
      end else if (act[k]) begin
        if (in_en) begin
          if (nq[k] >= skp[k]) sum[k] += int'(in_bit);
          nq[k]++;
          if (nq[k] == skp[k] + 8) begin
            act[k] = 0; hold[k] = 1; ed[k] = sum[k];
          end
        end
      end else if (start) begin
        act[k] = 1; nq[k] = 0; sum[k] = 0;
      end
    end
  endtask
  task automatic compare(input string tag);
    chk({tag, "_data0"}, int'(d0), ed[0]);
    chk({tag, "_valid0"}, int'(v0), int'(hold[0]));
    chk({tag, "_busy0"}, int'(b0), int'(act[0] | hold[0]));
    chk({tag, "_data1"}, int'(d1), ed[1]);
    chk({tag, "_valid1"}, int'(v1), int'(hold[1]));
    chk({tag, "_busy1"}, int'(b1), int'(act[1] | hold[1]));
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare("cyc");
  endtask
  task automatic drive(input logic s, input logic a, input logic b, input logic e, input logic r);
    start = s; abort = a; in_bit = b; in_en = e; out_ready = r;
  endtask
  initial begin
    logic [8:0] pat;
    model_reset();
    rst = 1;
    #1;
    compare("reset");
    #12 rst = 0;
    step();
    // all ones, every cycle qualified
    drive(1, 0, 1, 1, 1);
    step();
    start = 0;
    repeat (9) step();
    chk("s1_valid", int'(v0), 1);
    chk("s1_data", int'(d0), 8);
    step();
    chk("s1_valid_drop", int'(v0), 0);
    step();
    // leading skipped one must not be counted
    pat = 9'b110110010;
    drive(1, 0, 0, 1, 1);
    step();
    start = 0;
    for (int i = 8; i >= 0; i--) begin
      in_bit = pat[i];
      step();
    end
    chk("s2_data", int'(d0), 4);
    repeat (2) step();
    // ones only arrive on unqualified cycles
    drive(1, 0, 0, 1, 1);
    step();
    start = 0;
    for (int j = 0; j < 20; j++) begin
      in_en = (j % 2 == 1);
      in_bit = !in_en;
      step();
      if (j == 15) begin
        chk("s3_valid1", int'(v1), 1);
        chk("s3_data1", int'(d1), 0);
      end
    end
    repeat (2) step();
    // held result with start pulses during HOLD
    drive(1, 0, 1, 1, 0);
    step();
    start = 0;
    repeat (12) step();
    for (int j = 0; j < 5; j++) begin
      start = 1;
      step();
      chk("s4_hold_data", int'(d0), 8);
    end
    out_ready = 1;
    step();
    chk("s4_idle", int'(b0), 0);
    in_bit = 0;
    step();
    start = 0;
    chk("s4_restart", int'(b0), 1);
    repeat (12) step();
    // abort mid-RUN, then abort+start together
    drive(1, 0, 1, 1, 1);
    step();
    start = 0;
    repeat (5) step();
    abort = 1;
    step();
    start = 1;
    step();
    drive(0, 0, 1, 1, 1);
    chk("s5_busy", int'(b0), 0);
    chk("s5_valid", int'(v0), 0);
    step();
    start = 1;
    step();
    start = 0;
    repeat (12) step();
    // asynchronous reset between edges mid-RUN
    start = 1;
    step();
    start = 0;
    repeat (4) step();
    #3 rst = 1;
    #1 model_reset();
    compare("arst");
    chk("arst_data", int'(d0), 0);
    #2 rst = 0;
    drive(1, 0, 0, 1, 1);
    step();
    start = 0;
    repeat (12) step();
    chk("s6_data", int'(d0), 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      drive(logic'($urandom_range(7) == 0), logic'($urandom_range(39) == 0), logic'($urandom_range(1)),
            logic'($urandom_range(3) != 0), logic'($urandom_range(1)));
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
